// File: rtl/serial_adder_if.sv
// serial_adder_if: start/operand/result bundle for the bit-serial adder.
// The ovf_o member exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             cout_o;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_o;
`endif

  // Requester side: drives the operands, observes status and result.
  modport master (
    output start_i, a_i, b_i, cin_i,
    input  busy_o, done_o, sum_o, cout_o
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf_o
`endif
  );

  // Adder side.
  modport slave (
    input  start_i, a_i, b_i, cin_i,
    output busy_o, done_o, sum_o, cout_o
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf_o
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, LSB first, one registered full-adder
// cell. {cout, sum} = a + b + cin after WIDTH shift cycles.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the signed-overflow flag.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk_i,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic ha1_s, ha1_c, ha2_c;
  logic fa_s, fa_c;

  // Full-adder cell built as two half adders plus an OR.
  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    ha1_c = a_q[0] & b_q[0];
    fa_s  = ha1_s ^ c_q;
    ha2_c = ha1_s & c_q;
    fa_c  = ha1_c | ha2_c;
  end

  // Next-state logic: operand capture, serial shift and result commit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          c_d     = bus.cin_i;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        c_d    = fa_c;
        cnt_d  = cnt_q + 1'b1;
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds s0.
        psum_d = (psum_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = psum_d;
          cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB cell on this final cycle.
          ovf_d   = c_q ^ fa_c;
`endif
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy_o = (state_q == ST_SHIFT);
  assign bus.done_o = (state_q == ST_DONE);
  assign bus.sum_o  = sum_q;
  assign bus.cout_o = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst_n;
  int unsigned checks;
  int unsigned failures;
  logic [7:0] prev_sum;
  logic       prev_cout;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.start_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.cin_i   = c;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.a_i     = ~a;
    bus.b_i     = ~b;
    bus.cin_i   = ~c;
  endtask

  // Wait for done_o (bounded), optionally pulsing a stray start in SHIFT
  // cycle index inj; returns in the done_o cycle.
  task automatic wait_done(input string tag, input logic [7:0] es, input logic ec,
                           input logic eo, input int inj);
    int n;
    int busy_cnt;
    logic held_ok;
    n = 0;
    busy_cnt = 0;
    held_ok = 1'b1;
    while (bus.done_o !== 1'b1 && n < 40) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (bus.sum_o !== prev_sum || bus.cout_o !== prev_cout) held_ok = 1'b0;
      if (n == inj) begin
        bus.start_i = 1'b1;
        bus.a_i     = 8'hFF;
        bus.b_i     = 8'hFF;
        bus.cin_i   = 1'b1;
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start_i = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
    check({tag, "_hold"}, 32'(held_ok), 32'd1);
    check({tag, "_sum"}, 32'(bus.sum_o), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout_o), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf_o), 32'(eo));
`else
    if (eo === 1'bx) $display("note: %s ovf expectation undefined", tag);
`endif
    prev_sum  = es;
    prev_cout = ec;
  endtask

  // One isolated operation followed by a check that done_o was a pulse.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] es, input logic ec,
                        input logic eo, input int inj);
    issue(a, b, c);
    wait_done(tag, es, ec, eo, inj);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(bus.done_o), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy_o), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    checks      = 0;
    failures    = 0;
    prev_sum    = 8'h00;
    prev_cout   = 1'b0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.cin_i   = 1'b0;

    #12;
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_sum",  32'(bus.sum_o),  32'd0);
    check("rst_cout", 32'(bus.cout_o), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf",  32'(bus.ovf_o),  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add5A33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, -1);
    run_op("addFF01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, -1);
    run_op("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, -1);
    run_op("sub10_05", 8'h10, 8'hFA, 1'b1, 8'h0B, 1'b1, 1'b0, -1);
    run_op("add7F_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, -1);

    // Stray start in the 3rd SHIFT cycle must be ignored.
    run_op("ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 2);

    // Back-to-back: restart in the done_o cycle.
    issue(8'h5A, 8'h33, 1'b0);
    wait_done("b2b_first", 8'h8D, 1'b0, 1'b1, -1);
    issue(8'hFF, 8'h01, 1'b0);
    check("b2b_busy_next", 32'(bus.busy_o), 32'd1);
    check("b2b_done_low",  32'(bus.done_o), 32'd0);
    check("b2b_sum_held",  32'(bus.sum_o),  32'h8D);
    wait_done("b2b_second", 8'h00, 1'b1, 1'b0, -1);
    @(posedge clk); #1;
    check("b2b_done_pulse", 32'(bus.done_o), 32'd0);
    @(negedge clk);

    // Reset in the 4th SHIFT cycle.
    issue(8'h80, 8'h80, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_done", 32'(bus.done_o), 32'd0);
    check("mid_rst_sum",  32'(bus.sum_o),  32'd0);
    check("mid_rst_cout", 32'(bus.cout_o), 32'd1 - 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("mid_rst_ovf",  32'(bus.ovf_o),  32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen++;
    end
    check("mid_rst_no_done", 32'(seen), 32'd0);
    prev_sum  = 8'h00;
    prev_cout = 1'b0;
    @(negedge clk);
    run_op("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder: accepts two WIDTH-bit operands plus carry-in on a start handshake and produces their sum one bit per clock, LSB first, through a single registered full-adder cell. It is the additive counterpart of the combinational subtractor datapath in the lab ALU. It is intended for area-constrained arithmetic where latency of WIDTH+1 cycles is acceptable. Subtraction is obtained externally by presenting ~B with carry-in 1.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..32.

- clk_i  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only in IDLE or DONE.
- a_i  input  WIDTH  operand A, captured on accepted start.
- b_i  input  WIDTH  operand B, captured on accepted start.
- cin_i  input  1  carry-in, captured on accepted start.
- busy_o  output  1  high while in SHIFT.
- done_o  output  1  one-cycle pulse: result valid.
- sum_o  output  WIDTH  result register.
- cout_o  output  1  final carry-out.
- ovf_o  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: start_i=1 -> latch a_i, b_i into shift registers, carry FF <= cin_i, bit counter <= 0, go SHIFT. start_i=0 -> stay.
- SHIFT: per cycle, full-adder cell computes s = a[0]^b[0]^c, c' = a[0]&b[0] | c&(a[0]^b[0]). The cell is two half-adder stages plus OR. s shifts into partial-sum MSB; A, B shift right; carry FF <= c'; counter++. start_i ignored.
- After the WIDTH-th SHIFT cycle (counter = WIDTH-1): sum_o <= completed partial sum, cout_o <= c', go DONE.
- DONE: done_o=1 for exactly this cycle. start_i=1 -> accepted exactly as in IDLE, go SHIFT (back-to-back). Otherwise go IDLE.
- sum_o/cout_o (and ovf_o) change only on entry to DONE; they hold between operations and through subsequent SHIFT phases.
- Arithmetic: {cout_o, sum_o} = a + b + cin modulo 2^(WIDTH+1); unsigned, no saturation.
- Reset (any time, including mid-SHIFT) -> immediately IDLE. All outputs 0; shift registers, carry FF and counter cleared. The in-flight operation is discarded; no done_o for it.

## Timing
- Reset values: busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0.
- Start accepted at edge E0. busy_o is high after E0 through E_WIDTH (WIDTH cycles). done_o is high after E_WIDTH until E_WIDTH+1.
- Latency, start to done_o: WIDTH+1 edges. Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- All outputs are registered; no combinational path from inputs to outputs.
- a_i/b_i/cin_i need only be valid in the accepting cycle.

## Configuration
- SERIAL_ADDER_OVF_EN defined: ovf_o port exists.
  - On entry to DONE, ovf_o <= carry into MSB XOR carry out of MSB, i.e. the two's-complement overflow of a+b+cin.
  - ovf_o holds with sum_o and resets to 0.
- Not defined: ovf_o port and its register are absent; all other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> after 9 cycles done_o pulse, sum_o=0x8D, cout_o=0, ovf_o=1 (when enabled).
- a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1, ovf_o=0. Separately, a=0x00, b=0x00, cin=1 -> sum_o=0x01, cout_o=0.
- Subtract 0x10-0x05: a=0x10, b=0xFA, cin=1 -> sum_o=0x0B, cout_o=1 (no borrow).
- Pulse start_i with new operands in the 3rd SHIFT cycle -> ignored; result is still that of the first operands; done_o pulses once; busy_o stays high for exactly 8 cycles.
- Assert start_i with new operands in the done_o cycle -> busy_o high next cycle; second done_o 9 cycles after the first; the first sum_o holds until then.
- Drop rst_n in the 4th SHIFT cycle -> all outputs 0 asynchronously; state IDLE; no done_o. A new start after release gives a correct result.
